// File: rtl/vend_pkg.sv
// Shared codes and encodings for the vending FSM and its output-side dispenser.
package vend_pkg;

  typedef enum logic [1:0] {
    CR_NONE = 2'b00,
    CR_ONE  = 2'b01,
    CR_TWO  = 2'b10,
    CR_RSVD = 2'b11
  } cash_ret_e;

  typedef enum logic [1:0] {
    TK_0  = 2'b00,
    TK_10 = 2'b01,
    TK_20 = 2'b10
  } cash_in_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VEND,
    ST_EJECT_WAIT,
    ST_EJECT_PULSE,
    ST_EJECT_GAP,
    ST_FAULT
  } disp_state_e;

  // Change code to number of 10-Tk coins; the reserved code pays nothing.
  function automatic logic [1:0] coins_of(input logic [1:0] cr);
    case (cr)
      CR_ONE:  coins_of = 2'd1;
      CR_TWO:  coins_of = 2'd2;
      default: coins_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_req_fifo.sv
// Two-entry request FIFO of coin counts; a push into a full FIFO is accepted only
// when a pop happens on the same edge.
module vend_req_fifo
  import vend_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [1:0] wdata_i,
  output logic [1:0] rdata_o,
  output logic       full_o,
  output logic       empty_o
);

  logic [1:0][1:0] mem_q;
  logic            wptr_q, rptr_q;
  logic [1:0]      cnt_q;
  logic            do_push, do_pop;

  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rptr_q];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q  <= '0;
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= wdata_i;
        wptr_q        <= ~wptr_q;
      end
      if (do_pop) rptr_q <= ~rptr_q;
      cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/vend_dispenser.sv
// Output-side dispenser: queues purchase results, times the product motor against
// the drop sensor and pulses the change hopper once per coin.
module vend_dispenser
  import vend_pkg::*;
#(
  parameter int MOTOR_TIMEOUT = 1000,
  parameter int COIN_PULSE    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       purchase,
  input  logic [1:0] cash_return,
  input  logic       vend_sensor,
  input  logic       hopper_ready,
  output logic       motor_on,
  output logic       coin_eject,
  output logic       busy,
  output logic       fault,
  output logic       overflow,
  output logic [7:0] vend_count
);

  localparam int TMAX = (MOTOR_TIMEOUT > COIN_PULSE) ? MOTOR_TIMEOUT : COIN_PULSE;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] T_MOTOR_LAST = TW'(MOTOR_TIMEOUT - 1);
  localparam logic [TW-1:0] T_COIN_LAST  = TW'(COIN_PULSE - 1);

  disp_state_e state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    coins_q, coins_d;
  logic          motor_q, motor_d;
  logic          coin_q, coin_d;
  logic          fault_q, fault_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    vcnt_q, vcnt_d;

  logic       push, pop, full, empty;
  logic [1:0] head;

  // Requests are frozen out once the motor has faulted.
  assign push = purchase && (state_q != ST_FAULT);
  assign pop  = (state_q == ST_IDLE) && !empty;

  vend_req_fifo u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push_i (push),
    .pop_i  (pop),
    .wdata_i(coins_of(cash_return)),
    .rdata_o(head),
    .full_o (full),
    .empty_o(empty)
  );

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    coins_d = coins_q;
    motor_d = motor_q;
    coin_d  = coin_q;
    fault_d = fault_q;
    ovf_d   = ovf_q | (push && full && !pop);
    vcnt_d  = vcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          coins_d = head;
          timer_d = '0;
          motor_d = 1'b1;
          state_d = ST_VEND;
        end
      end
      ST_VEND: begin
        if (vend_sensor) begin
          motor_d = 1'b0;
          vcnt_d  = vcnt_q + 8'd1;
          state_d = (coins_q != 2'd0) ? ST_EJECT_WAIT : ST_IDLE;
        end else if (timer_q == T_MOTOR_LAST) begin
          motor_d = 1'b0;
          fault_d = 1'b1;
          state_d = ST_FAULT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_EJECT_WAIT: begin
        if (hopper_ready) begin
          coin_d  = 1'b1;
          timer_d = '0;
          state_d = ST_EJECT_PULSE;
        end
      end
      ST_EJECT_PULSE: begin
        if (timer_q == T_COIN_LAST) begin
          coin_d  = 1'b0;
          coins_d = coins_q - 2'd1;
          timer_d = '0;
          state_d = (coins_q == 2'd1) ? ST_IDLE : ST_EJECT_GAP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      // The WAIT cycle after the gap adds one more low cycle before the next pulse.
      ST_EJECT_GAP: begin
        if (timer_q == T_COIN_LAST) state_d = ST_EJECT_WAIT;
        else                        timer_d = timer_q + TW'(1);
      end
      ST_FAULT: begin
        motor_d = 1'b0;
        coin_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      coins_q <= 2'd0;
      motor_q <= 1'b0;
      coin_q  <= 1'b0;
      fault_q <= 1'b0;
      ovf_q   <= 1'b0;
      vcnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      coins_q <= coins_d;
      motor_q <= motor_d;
      coin_q  <= coin_d;
      fault_q <= fault_d;
      ovf_q   <= ovf_d;
      vcnt_q  <= vcnt_d;
    end
  end

  assign motor_on   = motor_q;
  assign coin_eject = coin_q;
  assign busy       = (state_q != ST_IDLE) || !empty;
  assign fault      = fault_q;
  assign overflow   = ovf_q;
  assign vend_count = vcnt_q;

endmodule

// File: tb/tb_vend_dispenser.sv
// Scoreboard bench: a job-level schedule model predicts output edge times; a
// monitor compares every observed output transition against those predictions.
module tb_vend_dispenser;

  localparam int MT    = 16;
  localparam int CP    = 2;
  localparam int NE    = 8192;
  localparam int NEVER = 1 << 30;

  logic       clk = 1'b0, reset = 1'b1;
  logic       purchase = 1'b0, vend_sensor = 1'b0, hopper_ready = 1'b0;
  logic [1:0] cash_return = 2'b00;
  logic       motor_on, coin_eject, busy, fault, overflow;
  logic [7:0] vend_count;

  vend_dispenser #(.MOTOR_TIMEOUT(MT), .COIN_PULSE(CP)) dut (
    .clk(clk), .reset(reset), .purchase(purchase), .cash_return(cash_return),
    .vend_sensor(vend_sensor), .hopper_ready(hopper_ready), .motor_on(motor_on),
    .coin_eject(coin_eject), .busy(busy), .fault(fault), .overflow(overflow),
    .vend_count(vend_count)
  );

  always #5 clk = ~clk;

  int ecnt = 0;
  always @(posedge clk) ecnt <= ecnt + 1;

  // Per-edge stimulus and expected-busy tables, indexed by posedge number.
  bit         purch_a[NE], sens_a[NE], hop_a[NE], bexp_a[NE];
  logic [1:0] cr_a[NE];

  typedef struct { int e; int v; } vc_t;
  typedef struct { int gap; logic [1:0] cr; int d; int h0; int h1; } job_t;
  int   mq[$], cq[$], fq[$], oq[$], accS[$];
  vc_t  vq[$];
  job_t jobs[$];

  int total = 0, bad = 0;
  bit mon_en = 1'b0;
  int F, fault_edge, exp_vc, R;
  bit ovf_seen;
  logic pm = 0, pc = 0, pf = 0, po = 0;
  logic [7:0] pv = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, ecnt);
    end
  endtask

  task automatic addj(input int gap, input logic [1:0] cr, input int d, input int h0, input int h1);
    job_t j;
    j.gap = gap; j.cr = cr; j.d = d; j.h0 = h0; j.h1 = h1;
    jobs.push_back(j);
  endtask

  // Jobs are served in order; each one's start edge is max(push+1, dispenser free edge).
  // d==0 means the sensor never fires for that job.
  task automatic plan(input int base);
    int p, s, w, c, h, np;
    vc_t v;
    p = base;
    if (F < base) F = base;
    for (int e = base; e < NE; e++) begin
      purch_a[e] = 0; sens_a[e] = 0; bexp_a[e] = 0;
      hop_a[e] = 1'($urandom); cr_a[e] = 2'($urandom);
    end
    foreach (jobs[i]) begin
      p += jobs[i].gap;
      purch_a[p] = 1; cr_a[p] = jobs[i].cr;
      if (p > fault_edge) continue;
      np = 0;
      foreach (accS[k]) if (accS[k] > p) np++;
      if (np >= 2) begin
        if (!ovf_seen) oq.push_back(p);
        ovf_seen = 1;
        continue;
      end
      s = (p + 1 > F) ? p + 1 : F;
      accS.push_back(s);
      if (s >= NEVER) continue;
      mq.push_back(s);
      if (jobs[i].d == 0) begin
        mq.push_back(s + MT);
        fq.push_back(s + MT);
        fault_edge = s + MT;
        F = NEVER;
        for (int e = p; e < NE; e++) bexp_a[e] = 1;
        continue;
      end
      sens_a[s + jobs[i].d] = 1;
      mq.push_back(s + jobs[i].d);
      exp_vc = (exp_vc + 1) % 256;
      v.e = s + jobs[i].d; v.v = exp_vc;
      vq.push_back(v);
      c = (jobs[i].cr == 2'b01) ? 1 : (jobs[i].cr == 2'b10) ? 2 : 0;
      w = s + jobs[i].d + 1;
      F = w;
      for (int k = 0; k < c; k++) begin
        h = (k == 0) ? jobs[i].h0 : jobs[i].h1;
        for (int e = w; e < w + h; e++) hop_a[e] = 0;
        hop_a[w + h] = 1;
        cq.push_back(w + h);
        cq.push_back(w + h + CP);
        F = w + h + CP + 1;
        w = w + h + 2 * CP + 1;
      end
      for (int e = p; e <= F - 2; e++) bexp_a[e] = 1;
    end
    jobs.delete();
  endtask

  task automatic wait_edge(input int target);
    while (ecnt < target) @(negedge clk);
  endtask

  task automatic clear_model();
    mq.delete(); cq.delete(); fq.delete(); oq.delete(); vq.delete(); accS.delete();
  endtask

  // Driver: inputs for the next posedge are applied on the preceding negedge.
  initial forever begin
    @(negedge clk);
    if (ecnt + 1 < NE) begin
      purchase     = purch_a[ecnt + 1];
      cash_return  = cr_a[ecnt + 1];
      vend_sensor  = sens_a[ecnt + 1];
      hopper_ready = hop_a[ecnt + 1];
    end
  end

  // Monitor: every output transition consumes the next predicted edge time.
  initial forever begin
    vc_t x;
    @(negedge clk);
    if (mon_en) begin
      if (motor_on !== pm) begin
        if (mq.size() == 0) chk("motor_extra", ecnt, -1);
        else chk("motor_edge", ecnt, mq.pop_front());
      end
      if (coin_eject !== pc) begin
        if (cq.size() == 0) chk("coin_extra", ecnt, -1);
        else chk("coin_edge", ecnt, cq.pop_front());
      end
      if (fault !== pf) begin
        if (fq.size() == 0) chk("fault_extra", ecnt, -1);
        else chk("fault_edge", ecnt, fq.pop_front());
      end
      if (overflow !== po) begin
        if (oq.size() == 0) chk("ovf_extra", ecnt, -1);
        else chk("ovf_edge", ecnt, oq.pop_front());
      end
      if (vend_count !== pv) begin
        if (vq.size() == 0) chk("vcnt_extra", ecnt, -1);
        else begin
          x = vq.pop_front();
          chk("vcnt_edge", ecnt, x.e);
          chk("vcnt_val", int'(vend_count), x.v);
        end
      end
      if (ecnt < NE) chk("busy", int'(busy), int'(bexp_a[ecnt]));
    end
    pm = motor_on; pc = coin_eject; pf = fault; po = overflow; pv = vend_count;
  end

  initial begin
    for (int e = 0; e < NE; e++) cr_a[e] = 2'b00;
    F = 0; fault_edge = NEVER; exp_vc = 0; ovf_seen = 0;

    repeat (3) @(negedge clk);
    chk("rst_motor", int'(motor_on), 0);
    chk("rst_coin", int'(coin_eject), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_fault", int'(fault), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_vcnt", int'(vend_count), 0);
    reset = 1'b0;
    mon_en = 1'b1;

    // Directed jobs, then a random mix that also exercises queueing and drops.
    addj(1, 2'b00, 3, 0, 0);
    addj(12, 2'b10, 2, 0, 0);
    addj(20, 2'b01, 8, 2, 0);
    addj(3, 2'b00, 2, 0, 0);
    addj(1, 2'b10, 3, 1, 1);
    addj(1, 2'b01, 2, 0, 0);
    addj(60, 2'b11, 1, 0, 0);
    addj(30, 2'b01, 2, 10, 0);
    for (int i = 0; i < 40; i++)
      addj(($urandom_range(0, 3) == 0) ? 1 : int'($urandom_range(2, 30)), 2'($urandom),
           int'($urandom_range(1, MT)), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
    plan(ecnt + 2);
    wait_edge(F + 5);
    chk("seg1_motor_left", mq.size(), 0);
    chk("seg1_coin_left", cq.size(), 0);
    chk("seg1_vcnt_left", vq.size(), 0);
    chk("seg1_ovf_left", oq.size(), 0);
    chk("seg1_vcnt", int'(vend_count), exp_vc);
    chk("seg1_ovf", int'(overflow), int'(ovf_seen));

    // Reset in the middle of a coin pulse with two requests still queued.
    mon_en = 1'b0;
    clear_model();
    addj(2, 2'b01, 2, 0, 0);
    addj(2, 2'b00, 1, 0, 0);
    addj(1, 2'b01, 1, 0, 0);
    plan(ecnt + 2);
    R = cq[0];
    wait_edge(R);
    chk("pre_rst_coin", int'(coin_eject), 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_coin", int'(coin_eject), 0);
    chk("mid_rst_motor", int'(motor_on), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_fault", int'(fault), 0);
    chk("mid_rst_ovf", int'(overflow), 0);
    chk("mid_rst_vcnt", int'(vend_count), 0);
    for (int e = ecnt + 1; e < NE; e++) begin purch_a[e] = 0; sens_a[e] = 0; end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (8) begin
      @(negedge clk);
      chk("post_rst_motor", int'(motor_on), 0);
      chk("post_rst_busy", int'(busy), 0);
    end
    clear_model();
    exp_vc = 0; ovf_seen = 0; F = ecnt + 1;
    mon_en = 1'b1;

    // Motor timeout, then a later purchase that must be ignored.
    addj(3, 2'b10, 0, 0, 0);
    addj(40, 2'b01, 3, 0, 0);
    plan(ecnt + 2);
    wait_edge(fault_edge + 50);
    chk("flt_fault", int'(fault), 1);
    chk("flt_busy", int'(busy), 1);
    chk("flt_motor", int'(motor_on), 0);
    chk("flt_coin", int'(coin_eject), 0);
    chk("flt_vcnt", int'(vend_count), 0);
    chk("flt_motor_left", mq.size(), 0);
    chk("flt_fault_left", fq.size(), 0);
    chk("flt_coin_left", cq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
